// File: rtl/bitwise_op_pkg.sv
// Shared types for the bitwise operation pipe.
//   op_e    : operation selector carried on in_op
//   state_e : accumulate-packet FSM state
package bitwise_op_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2,
        OP_ACC = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/bitwise_op_fifo.sv
// Result FIFO for bitwise_op_pipe. Registered storage, read data taken
// straight from the head entry (no push-to-pop bypass).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push_i, wdata_i : write one entry (caller guarantees space or a pop)
//   pop_i           : remove head entry (ignored when empty)
//   rdata_o         : head entry
//   full_o, empty_o : occupancy flags
//   count_o         : occupancy, 0..DEPTH
module bitwise_op_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;

    assign do_pop = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == DEPTH[AW:0]);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/bitwise_op_pipe.sv
// Multi-lane bitwise operation pipe with accumulate mode and result FIFO.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand beat handshake
//   in_a, in_b          : operands, lane k at [k*WIDTH +: WIDTH]
//   in_op               : 0 AND, 1 OR, 2 XOR, 3 accumulating AND
//   in_last             : closes an accumulate packet
//   out_valid/out_ready : result handshake
//   out_w, out_zero     : result lanes and per-lane all-zero flags
//   out_count           : FIFO occupancy
//
// state   | meaning
// ST_IDLE | no packet open; op decoded from in_op
// ST_ACC  | accumulate packet open; every beat ANDs into acc
module bitwise_op_pipe
    import bitwise_op_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*WIDTH-1:0]   in_a,
    input  logic [CHANNELS*WIDTH-1:0]   in_b,
    input  logic [1:0]                  in_op,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHANNELS*WIDTH-1:0]   out_w,
    output logic [CHANNELS-1:0]         out_zero,
    output logic [$clog2(DEPTH):0]      out_count
);

    localparam int DW = CHANNELS * WIDTH;
    localparam int EW = DW + CHANNELS;

    state_e         state_q, state_d;
    logic [DW-1:0]  acc_q, acc_d;
    op_e            op;
    logic           in_acc;
    logic           non_push;
    logic           accept;
    logic           push;
    logic [DW-1:0]  lane_r;
    logic [DW-1:0]  acc_next;
    logic [DW-1:0]  push_w;
    logic [CHANNELS-1:0] push_zero;
    logic [EW-1:0]  fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;

    assign op = op_e'(in_op);

    // An open packet forces accumulate regardless of in_op.
    assign in_acc   = (state_q == ST_ACC) || (op == OP_ACC);
    assign non_push = in_acc && !in_last;

    // A beat that only updates acc needs no FIFO space.
    assign in_ready = !rst && (!fifo_full || out_ready || non_push);
    assign accept   = in_valid && in_ready;

    // Lanes never interact, so whole-vector bitwise ops are per-lane ops.
    always_comb begin
        lane_r = in_a & in_b;
        case (op)
            OP_OR:   lane_r = in_a | in_b;
            OP_XOR:  lane_r = in_a ^ in_b;
            default: lane_r = in_a & in_b;
        endcase
    end

    assign acc_next = (state_q == ST_ACC) ? (acc_q & in_a & in_b) : (in_a & in_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept && in_acc) begin
            state_d = in_last ? ST_IDLE : ST_ACC;
        end
    end

    always_comb begin
        acc_d  = acc_q;
        push   = 1'b0;
        push_w = lane_r;
        if (accept) begin
            if (in_acc) begin
                push_w = acc_next;
                if (in_last) push = 1'b1;
                else         acc_d = acc_next;
            end else begin
                push = 1'b1;
            end
        end
    end

    always_comb begin
        push_zero = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            push_zero[k] = (push_w[k*WIDTH +: WIDTH] == '0);
        end
    end

    bitwise_op_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (out_ready),
        .wdata_i ({push_zero, push_w}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (out_count)
    );

    assign out_valid = !fifo_empty;
    assign out_w     = fifo_rdata[DW-1:0];
    assign out_zero  = fifo_rdata[EW-1:DW];

endmodule

// File: tb/tb_bitwise_op_pipe.sv
module tb_bitwise_op_pipe;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int D  = 2;
    localparam int DW = W * C;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [1:0]    in_op = 2'd0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_w;
    logic [C-1:0]  out_zero;
    logic [CW-1:0] out_count;

    bitwise_op_pipe #(.WIDTH(W), .CHANNELS(C), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_w     (out_w),
        .out_zero  (out_zero),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] w;
        logic [C-1:0]  z;
    } res_t;

    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: packet open flag, per-lane accumulator, occupancy.
    bit   in_pkt = 0;
    int unsigned acc_lane [C];
    int   occ = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock cycle: check post-edge state, drive inputs, check in_ready,
    // then advance the model for the upcoming edge.
    task automatic cycle(input logic r, input logic v, input logic [1:0] op, input logic l,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ordy);
        bit eff, nonpush, exp_ready, do_push;
        int unsigned res [C];
        res_t e;
        @(posedge clk);
        #2;
        check("out_valid", {63'd0, out_valid}, {63'd0, occ > 0});
        check("out_count", {{(64-CW){1'b0}}, out_count}, 64'(occ));
        rst       = r;
        in_valid  = v;
        in_op     = op;
        in_last   = l;
        in_a      = a;
        in_b      = b;
        out_ready = ordy & ~r;
        #1;
        eff       = in_pkt || (op == 2'd3);
        nonpush   = eff && !l;
        exp_ready = !r && (occ < D || ordy || nonpush);
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        do_push = 0;
        if (r) begin
            exp_q.delete();
            in_pkt = 0;
            for (int k = 0; k < C; k++) acc_lane[k] = 0;
            occ = 0;
        end else begin
            if (v && exp_ready) begin
                for (int k = 0; k < C; k++) begin
                    int unsigned av, bv;
                    av = a[k*W +: W];
                    bv = b[k*W +: W];
                    if (eff) begin
                        res[k] = av & bv;
                        if (in_pkt) res[k] = res[k] & acc_lane[k];
                    end else if (op == 2'd0) res[k] = av & bv;
                    else if (op == 2'd1)     res[k] = av | bv;
                    else                     res[k] = av ^ bv;
                end
                if (nonpush) begin
                    for (int k = 0; k < C; k++) acc_lane[k] = res[k];
                    in_pkt = 1;
                end else begin
                    in_pkt = 0;
                    do_push = 1;
                    for (int k = 0; k < C; k++) begin
                        e.w[k*W +: W] = res[k][W-1:0];
                        e.z[k]        = (res[k] == 0);
                    end
                    exp_q.push_back(e);
                end
            end
            occ = occ + (do_push ? 1 : 0) - ((occ > 0 && ordy) ? 1 : 0);
        end
    endtask

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] x;
        for (int k = 0; k < C; k++) begin
            x[k*W +: W] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
        end
        return x;
    endfunction

    localparam logic [DW-1:0] ONES = '1;

    initial begin
        fork
            begin : driver
                // Reset held two cycles with in_valid asserted.
                cycle(1, 1, 2'd0, 0, '0, '0, 1);
                cycle(1, 1, 2'd0, 0, '0, '0, 1);
                cycle(0, 0, 2'd0, 0, '0, '0, 1);

                // Basic ops, one cycle latency each.
                cycle(0, 1, 2'd0, 0, 32'hF00FAAFF, 32'h3C3C5500, 1);
                cycle(0, 0, 2'd0, 0, '0, '0, 1);
                check("and_w", 64'(out_w), 64'h300C0000);
                check("and_zero", 64'(out_zero), 64'h3);
                cycle(0, 1, 2'd1, 0, 32'hF00FAAFF, 32'h3C3C5500, 1);
                cycle(0, 0, 2'd0, 0, '0, '0, 1);
                check("or_w", 64'(out_w), 64'hFC3FFFFF);
                check("or_zero", 64'(out_zero), 64'h0);
                cycle(0, 1, 2'd2, 0, 32'hF00FAAFF, 32'h3C3C5500, 1);
                cycle(0, 0, 2'd0, 0, '0, '0, 1);
                check("xor_w", 64'(out_w), 64'hCC33FFFF);
                cycle(0, 0, 2'd0, 0, '0, '0, 1);

                // ACC 3-beat packet, op forced to 0 on the middle beat.
                cycle(0, 1, 2'd3, 0, 32'hFFFFFFFF, ONES, 1);
                cycle(0, 1, 2'd0, 0, 32'hF0F0F0F0, ONES, 1);
                cycle(0, 1, 2'd3, 1, 32'h3C3C3C3C, ONES, 1);
                check("acc_no_early_out", {63'd0, out_valid}, 64'd0);
                cycle(0, 0, 2'd0, 0, '0, '0, 1);
                check("acc_w", 64'(out_w), 64'h30303030);
                cycle(0, 0, 2'd0, 0, '0, '0, 1);

                // Backpressure at DEPTH=2, then simultaneous push/pop when full.
                cycle(0, 1, 2'd0, 0, 32'h11111111, ONES, 0);
                cycle(0, 1, 2'd1, 0, 32'h22222222, '0, 0);
                cycle(0, 1, 2'd2, 0, 32'h33333333, '0, 0);
                check("bp_ready_low", {63'd0, in_ready}, 64'd0);
                cycle(0, 1, 2'd2, 0, 32'h33333333, '0, 1);
                cycle(0, 0, 2'd0, 0, '0, '0, 0);
                check("bp_count", 64'(out_count), 64'd2);
                // Non-pushing ACC beat accepted while full.
                cycle(0, 1, 2'd3, 0, 32'h0F0F0F0F, ONES, 0);
                check("full_acc_ready", {63'd0, in_ready}, 64'd1);
                cycle(0, 1, 2'd3, 1, ONES, ONES, 1);
                for (int i = 0; i < 4; i++) cycle(0, 0, 2'd0, 0, '0, '0, 1);

                // Reset mid-packet discards the partial accumulator.
                cycle(0, 1, 2'd3, 0, 32'hF0F0F0F0, ONES, 1);
                cycle(0, 1, 2'd3, 0, 32'hF0F0F0F0, ONES, 1);
                cycle(1, 0, 2'd0, 0, '0, '0, 1);
                cycle(0, 1, 2'd3, 1, 32'h0F0F0F0F, ONES, 1);
                cycle(0, 0, 2'd0, 0, '0, '0, 1);
                check("rst_acc_w", 64'(out_w), 64'h0F0F0F0F);
                cycle(0, 0, 2'd0, 0, '0, '0, 1);

                // Random soak.
                for (int i = 0; i < 10000; i++) begin
                    logic [1:0] rop;
                    rop = 2'($urandom_range(0, 3));
                    cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), rop,
                          ($urandom_range(0, 2) == 0), rnd_vec(), rnd_vec(),
                          ($urandom_range(0, 3) != 0));
                end

                // Drain, bounded.
                for (int i = 0; i < 16 && occ > 0; i++) cycle(0, 0, 2'd0, 0, '0, '0, 1);
                cycle(0, 0, 2'd0, 0, '0, '0, 1);
                check("drained_occ", 64'(occ), 64'd0);
                check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_output", 64'(out_w), 64'd0);
                            fails += (out_w == '0) ? 1 : 0;
                        end else begin
                            res_t e;
                            e = exp_q.pop_front();
                            check("sb_w", 64'(out_w), 64'(e.w));
                            check("sb_zero", 64'(out_zero), 64'(e.z));
                        end
                    end
                end
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
